// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mc_ctrl_pkg - opcodes, state encodings and datapath select codes
// Revision: 1.0
// ============================================================================
package mc_ctrl_pkg;

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_BNE  = 6'b000101;
  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;

  localparam logic [3:0] c_ST_FETCH     = 4'd0;
  localparam logic [3:0] c_ST_DECODE    = 4'd1;
  localparam logic [3:0] c_ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] c_ST_MEM_RD    = 4'd3;
  localparam logic [3:0] c_ST_MEM_WB    = 4'd4;
  localparam logic [3:0] c_ST_MEM_WR    = 4'd5;
  localparam logic [3:0] c_ST_R_EXEC    = 4'd6;
  localparam logic [3:0] c_ST_R_WB      = 4'd7;
  localparam logic [3:0] c_ST_BRANCH    = 4'd8;
  localparam logic [3:0] c_ST_JUMP      = 4'd9;
  localparam logic [3:0] c_ST_ADDI_EXEC = 4'd10;
  localparam logic [3:0] c_ST_ADDI_WB   = 4'd11;

  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] c_SRCB_RT     = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
  localparam logic [1:0] c_SRCB_IMM    = 2'b10;
  localparam logic [1:0] c_SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_sat_counter.sv
`default_nettype none
// ============================================================================
// mc_sat_counter - width-parametrised up counter that holds at all-ones
// Revision: 1.0
// ============================================================================
module mc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control - Moore FSM sequencing multicycle MIPS datapath control
// Revision: 1.0
// ============================================================================
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit EN_BNE  = 1'b1,
  parameter bit EN_JUMP = 1'b1,
  parameter bit EN_ADDI = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNE,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_illegal;
  logic       r_illegal;
  ctrl_t      w_ctl;

  always_comb begin
    w_next    = c_ST_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      c_ST_FETCH:     w_next = mem_ready ? c_ST_DECODE : c_ST_FETCH;
      c_ST_DECODE: begin
        if ((opcode == c_OP_LW) || (opcode == c_OP_SW))             w_next = c_ST_MEM_ADDR;
        else if (opcode == c_OP_R)                                  w_next = c_ST_R_EXEC;
        else if ((opcode == c_OP_BEQ) || (EN_BNE && (opcode == c_OP_BNE))) w_next = c_ST_BRANCH;
        else if (EN_JUMP && (opcode == c_OP_J))                     w_next = c_ST_JUMP;
        else if (EN_ADDI && (opcode == c_OP_ADDI))                  w_next = c_ST_ADDI_EXEC;
        else                                                        w_illegal = 1'b1;
      end
      c_ST_MEM_ADDR:  w_next = (opcode == c_OP_LW) ? c_ST_MEM_RD : c_ST_MEM_WR;
      c_ST_MEM_RD:    w_next = mem_ready ? c_ST_MEM_WB : c_ST_MEM_RD;
      c_ST_MEM_WR:    w_next = mem_ready ? c_ST_FETCH : c_ST_MEM_WR;
      c_ST_R_EXEC:    w_next = c_ST_R_WB;
      c_ST_ADDI_EXEC: w_next = c_ST_ADDI_WB;
      default:        w_next = c_ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Gated by rst so an asserted reset silences the datapath without a clock edge.
  always_comb begin
    w_ctl = '0;
    if (!rst) begin
      case (r_state)
        c_ST_FETCH: begin
          w_ctl.mem_read  = 1'b1;
          w_ctl.alu_src_b = c_SRCB_FOUR;
          w_ctl.alu_op    = c_ALUOP_ADD;
          w_ctl.ir_write  = mem_ready;
          w_ctl.pc_write  = mem_ready;
        end
        c_ST_DECODE: begin
          w_ctl.alu_src_b = c_SRCB_IMM_SH;
          w_ctl.alu_op    = c_ALUOP_ADD;
        end
        c_ST_MEM_ADDR: begin
          w_ctl.alu_src_a = 1'b1;
          w_ctl.alu_src_b = c_SRCB_IMM;
        end
        c_ST_MEM_RD: begin
          w_ctl.mem_read = 1'b1;
          w_ctl.iord     = 1'b1;
        end
        c_ST_MEM_WB: begin
          w_ctl.reg_write  = 1'b1;
          w_ctl.mem_to_reg = 1'b1;
          w_ctl.instr_done = 1'b1;
        end
        c_ST_MEM_WR: begin
          w_ctl.mem_write  = 1'b1;
          w_ctl.iord       = 1'b1;
          w_ctl.instr_done = mem_ready;
        end
        c_ST_R_EXEC: begin
          w_ctl.alu_src_a = 1'b1;
          w_ctl.alu_src_b = c_SRCB_RT;
          w_ctl.alu_op    = c_ALUOP_FUNCT;
        end
        c_ST_R_WB: begin
          w_ctl.reg_write  = 1'b1;
          w_ctl.reg_dst    = 1'b1;
          w_ctl.instr_done = 1'b1;
        end
        c_ST_BRANCH: begin
          w_ctl.alu_src_a     = 1'b1;
          w_ctl.alu_src_b     = c_SRCB_RT;
          w_ctl.alu_op        = c_ALUOP_SUB;
          w_ctl.pc_write_cond = 1'b1;
          w_ctl.pc_source     = c_PCSRC_ALUOUT;
          w_ctl.branch_ne     = (opcode == c_OP_BNE);
          w_ctl.instr_done    = 1'b1;
        end
        c_ST_JUMP: begin
          w_ctl.pc_write   = 1'b1;
          w_ctl.pc_source  = c_PCSRC_JUMP;
          w_ctl.instr_done = 1'b1;
        end
        c_ST_ADDI_EXEC: begin
          w_ctl.alu_src_a = 1'b1;
          w_ctl.alu_src_b = c_SRCB_IMM;
          w_ctl.alu_op    = c_ALUOP_ADD;
        end
        c_ST_ADDI_WB: begin
          w_ctl.reg_write  = 1'b1;
          w_ctl.instr_done = 1'b1;
        end
        default: w_ctl = '0;
      endcase
    end
  end

  assign PCWrite     = w_ctl.pc_write;
  assign PCWriteCond = w_ctl.pc_write_cond;
  assign BranchNE    = w_ctl.branch_ne;
  assign IorD        = w_ctl.iord;
  assign MemRead     = w_ctl.mem_read;
  assign MemWrite    = w_ctl.mem_write;
  assign IRWrite     = w_ctl.ir_write;
  assign MemtoReg    = w_ctl.mem_to_reg;
  assign RegDst      = w_ctl.reg_dst;
  assign RegWrite    = w_ctl.reg_write;
  assign ALUSrcA     = w_ctl.alu_src_a;
  assign ALUSrcB     = w_ctl.alu_src_b;
  assign ALUOp       = w_ctl.alu_op;
  assign PCSource    = w_ctl.pc_source;
  assign instr_done  = w_ctl.instr_done;
  assign illegal_op  = r_illegal;

  mc_sat_counter #(
    .WIDTH (CNT_W)
  ) u_instr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_ctl.instr_done),
    .o_count (instr_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control - scoreboard bench over default, EN_BNE=0 and CNT_W=2 builds
// Revision: 1.0
// ============================================================================
module tb_multicycle_control;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
  localparam int S_RX = 6, S_RW = 7, S_BR = 8, S_J = 9, S_AX = 10, S_AW = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ready;
  logic [5:0] opcode;

  // Instance 0: defaults, 1: EN_BNE = 0, 2: CNT_W = 2
  wire [17:0] v   [3];
  wire [15:0] cnt [3];
  wire        ill [3];

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] sb_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 2) ? 2 : 16;
    multicycle_control #(
      .EN_BNE (g != 1), .EN_JUMP (1'b1), .EN_ADDI (1'b1), .CNT_W (W)
    ) u_dut (
      .clk (clk), .rst (rst), .opcode (opcode), .mem_ready (mem_ready),
      .PCWrite (v[g][17]), .PCWriteCond (v[g][16]), .BranchNE (v[g][15]),
      .IorD (v[g][14]), .MemRead (v[g][13]), .MemWrite (v[g][12]),
      .IRWrite (v[g][11]), .MemtoReg (v[g][10]), .RegDst (v[g][9]),
      .RegWrite (v[g][8]), .ALUSrcA (v[g][7]), .ALUSrcB (v[g][6:5]),
      .ALUOp (v[g][4:3]), .PCSource (v[g][2:1]), .instr_done (v[g][0]),
      .illegal_op (ill[g]), .instr_count (cnt[g][W-1:0])
    );
    if (W < 16) begin : g_pad
      assign cnt[g][15:W] = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ev(input int st, input logic mr, input logic [5:0] op);
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done;
    logic [1:0] srcb, aluop, pcsrc;
    {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done} = '0;
    {srcb, aluop, pcsrc} = '0;
    case (st)
      S_F:   begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      S_D:   srcb = 2'b11;
      S_MA:  begin srca = 1; srcb = 2'b10; end
      S_MR:  begin mrd = 1; iord = 1; end
      S_MWB: begin rw = 1; m2r = 1; done = 1; end
      S_MW:  begin mwr = 1; iord = 1; done = mr; end
      S_RX:  begin srca = 1; aluop = 2'b10; end
      S_RW:  begin rw = 1; rdst = 1; done = 1; end
      S_BR:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; bne = (op == OP_BNE); done = 1; end
      S_J:   begin pcw = 1; pcsrc = 2'b10; done = 1; end
      S_AX:  begin srca = 1; srcb = 2'b10; end
      S_AW:  begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, done};
  endfunction

  // Called right after a falling edge; drives one cycle and returns at the next falling edge.
  task automatic step(input string tag, input logic [5:0] op, input logic mr,
                      input int st, input int st_nb = -1);
    opcode    = op;
    mem_ready = mr;
    sb_q.push_back(ev(st, mr, op));
    sb_q.push_back(ev((st_nb < 0) ? st : st_nb, mr, op));
    sb_q.push_back(ev(st, mr, op));
    #1;
    chk({tag, "/def"}, v[0], sb_q.pop_front());
    chk({tag, "/nobne"}, v[1], sb_q.pop_front());
    chk({tag, "/cnt2"}, v[2], sb_q.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = OP_R; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", v[0], 18'd0);
    chk("rst_cnt", cnt[0], 0);
    chk("rst_ill", ill[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // lw, zero wait: 5 cycles
    step("lw_f", OP_LW, 1, S_F);
    step("lw_d", OP_LW, 1, S_D);
    step("lw_ma", OP_LW, 1, S_MA);
    step("lw_mr", OP_LW, 1, S_MR);
    chk("lw_cnt_before", cnt[0], 0);
    step("lw_wb", OP_LW, 1, S_MWB);
    chk("lw_cnt", cnt[0], 1);

    // sw with three wait cycles in MEM_WR: 7 cycles
    step("sw_f", OP_SW, 1, S_F);
    step("sw_d", OP_SW, 1, S_D);
    step("sw_ma", OP_SW, 1, S_MA);
    for (int i = 0; i < 3; i++) step("sw_wait", OP_SW, 0, S_MW);
    step("sw_wr", OP_SW, 1, S_MW);
    chk("sw_cnt", cnt[0], 2);

    // bne: branch on default build, illegal on EN_BNE=0 build
    step("bne_f", OP_BNE, 1, S_F);
    step("bne_d", OP_BNE, 1, S_D);
    step("bne_br", OP_BNE, 1, S_BR, S_F);
    chk("bne_ill_nb", ill[1], 1);
    chk("bne_ill_def", ill[0], 0);
    chk("bne_cnt_nb", cnt[1], 2);
    chk("bne_cnt_def", cnt[0], 3);

    do_reset();
    chk("rerst_ill_nb", ill[1], 0);
    step("beq_f", OP_BEQ, 1, S_F);
    step("beq_d", OP_BEQ, 1, S_D);
    step("beq_br", OP_BEQ, 1, S_BR);
    chk("beq_cnt", cnt[0], 1);
    step("bad_f", OP_BAD, 1, S_F);
    step("bad_d", OP_BAD, 1, S_D);
    chk("bad_ill", ill[0], 1);
    step("bad_back", OP_BAD, 0, S_F);
    chk("bad_cnt", cnt[0], 1);

    // six back-to-back jumps: 2-bit counter saturates at 3
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step("j_f", OP_J, 1, S_F);
      step("j_d", OP_J, 1, S_D);
      step("j_j", OP_J, 1, S_J);
      chk("j_cnt2", cnt[2], (i < 3) ? i + 1 : 3);
      chk("j_cnt16", cnt[0], i + 1);
    end

    // asynchronous reset during R_EXEC
    do_reset();
    step("pre_j_f", OP_J, 1, S_F);
    step("pre_j_d", OP_J, 1, S_D);
    step("pre_j_j", OP_J, 1, S_J);
    step("ab_f", OP_R, 1, S_F);
    step("ab_d", OP_R, 1, S_D);
    opcode = OP_R; mem_ready = 1'b1;
    #1;
    chk("ab_rx", v[0], ev(S_RX, 1, OP_R));
    #2;
    rst = 1'b1;
    #1;
    chk("ab_outs_def", v[0], 18'd0);
    chk("ab_outs_nb", v[1], 18'd0);
    chk("ab_cnt", cnt[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("ab_post_f_wait", OP_R, 0, S_F);
    step("ab_post_f", OP_R, 1, S_F);
    chk("ab_post_cnt", cnt[0], 0);

    // R then addi: 8 cycles, two retirements
    do_reset();
    step("r_f", OP_R, 1, S_F);
    step("r_d", OP_R, 1, S_D);
    step("r_x", OP_R, 1, S_RX);
    step("r_wb", OP_R, 1, S_RW);
    step("a_f", OP_ADDI, 1, S_F);
    step("a_d", OP_ADDI, 1, S_D);
    step("a_x", OP_ADDI, 1, S_AX);
    step("a_wb", OP_ADDI, 1, S_AW);
    chk("ra_cnt", cnt[0], 2);
    step("ra_back", OP_R, 0, S_F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder: a Moore FSM that sequences each MIPS instruction over 3–5 states.
- Drives datapath mux selects and register/memory enables, and stalls on a memory-ready handshake.
- Adds configurable bne/j/addi support, an illegal-opcode flag and a saturating retired-instruction counter.
- Sits between the instruction register opcode field and the shared multicycle datapath.

Parameters:
- EN_BNE, 1: 1 = opcode 000101 handled as branch-not-equal; 0 = treated as illegal.
- EN_JUMP, 1: 1 = opcode 000010 handled as jump; 0 = treated as illegal.
- EN_ADDI, 1: 1 = opcode 001000 handled as addi; 0 = treated as illegal.
- CNT_W, 16: width of instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if branch condition true.
- BranchNE  out  1  condition select: 0 = zero, 1 = not zero.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  A operand: 0 = PC, 1 = rs.
- ALUSrcB  out  2  B operand: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final state of each legal instruction.
- illegal_op  out  1  sticky flag, set on an unsupported opcode.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset:
  - rst high → state FETCH, illegal_op = 0, instr_count = 0.
  - While rst is high, every control output is 0.
  - Reset mid-instruction aborts it with no further enables asserted.
- Outputs decode from the state register only (Moore); any output not listed for a state is 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000.
- FETCH:
  - MemRead = 1, ALUSrcB = 01, ALUOp = 00.
  - IRWrite and PCWrite = mem_ready.
  - mem_ready = 0 → stay; mem_ready = 1 → DECODE.
- DECODE: ALUSrcB = 11, ALUOp = 00. Dispatch:
  - lw/sw → MEM_ADDR.
  - R → R_EXEC.
  - beq/bne(enabled) → BRANCH.
  - j(enabled) → JUMP.
  - addi(enabled) → ADDI_EXEC.
  - Otherwise → FETCH, set illegal_op; no instr_done, no count.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: MemRead = 1, IorD = 1. Wait for mem_ready, then → MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0, instr_done = 1 → FETCH.
- MEM_WR: MemWrite = 1, IorD = 1. Wait for mem_ready; instr_done = mem_ready; then → FETCH.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 → R_WB.
- R_WB: RegWrite = 1, RegDst = 1, instr_done = 1 → FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01.
  - BranchNE = (opcode == bne); instr_done = 1 → FETCH.
- JUMP: PCWrite = 1, PCSource = 10, instr_done = 1 → FETCH.
- ADDI_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00 → ADDI_WB.
- ADDI_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0, instr_done = 1 → FETCH.
- Latency with zero memory wait, cycles from entering FETCH until back in FETCH: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3. Each mem_ready-low cycle in a memory state adds 1.
- instr_count increments on each instr_done cycle and holds at 2^CNT_W−1.
- Unused state encodings → FETCH on the next edge.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants;
  - state encoding localparams (4-bit);
  - ALUOp, ALUSrcB and PCSource codes.
- One sub-module: mc_sat_counter (width-parametrised saturating counter with increment enable) for instr_count.

Test Plan:
- lw, mem_ready tied 1 → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB. RegWrite = MemtoReg = 1 only in cycle 5; instr_count 0→1.
- sw with mem_ready low 3 cycles in MEM_WR → MemWrite = IorD = 1 held for 4 cycles. instr_done only on the mem_ready cycle; total 7 cycles.
- bne, EN_BNE = 1 → cycle 3: PCWriteCond = 1, BranchNE = 1, ALUOp = 01, PCSource = 01. Rerun with EN_BNE = 0 → illegal_op = 1 after DECODE, back in FETCH, instr_count unchanged.
- CNT_W = 2, six back-to-back j instructions → instr_count 1, 2, 3, 3, 3, 3; each instruction takes 3 cycles.
- rst pulsed during R_EXEC → all outputs 0 immediately, without waiting for a clock edge. After release, state FETCH, instr_count = 0, no RegWrite issued for the aborted instruction.
- R then addi, mem_ready = 1 → R_WB has RegDst = 1; ADDI_WB has RegDst = 0, ALUSrcB = 10 in the prior cycle. 8 cycles total, instr_count = 2.
